// File: rtl/mpc_cfg_ctrl.sv
// Macro-select controller for the multi-project chip: WB register window plus a
// drain/isolate/reset/switch/release sequencer. Optional lock bit: `MPC_CFG_LOCK_EN.
module mpc_cfg_ctrl #(
    parameter int                      user_macros    = 4,
    parameter int                      cfg_bits       = 2,
    parameter int                      WB_data_bits   = 32,
    parameter int                      WB_addr_bits   = 32,
    parameter int                      WB_select_bits = 4,
    parameter logic [WB_addr_bits-1:0] CFG_BASE       = 32'h3000_F000,
    parameter int                      GUARD_CYCLES   = 16,
    parameter int                      RST_CYCLES     = 8
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic                      wbs_stb_i,
    input  logic                      wbs_cyc_i,
    input  logic                      wbs_we_i,
    input  logic [WB_select_bits-1:0] wbs_sel_i,
    input  logic [WB_data_bits-1:0]   wbs_dat_i,
    input  logic [WB_addr_bits-1:0]   wbs_adr_i,
    output logic                      wbs_ack_o,
    output logic [WB_data_bits-1:0]   wbs_dat_o,
    output logic [cfg_bits-1:0]       configuration,
    output logic [user_macros-1:0]    macro_rst_o,
    output logic                      io_isolate_o,
    output logic                      busy_o
);

    localparam int                  TMR_MAX      = (GUARD_CYCLES > RST_CYCLES) ? GUARD_CYCLES : RST_CYCLES;
    localparam int                  TMR_BITS     = $clog2(TMR_MAX + 1);
    localparam logic [TMR_BITS-1:0] GUARD_LOAD   = TMR_BITS'(GUARD_CYCLES - 1);
    localparam logic [TMR_BITS-1:0] RELEASE_LOAD = TMR_BITS'(RST_CYCLES - 1);
    localparam logic [7:0]          NUM_MACROS   = 8'(user_macros);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_ISOLATE,
        S_SWITCH,
        S_RELEASE
    } state_t;

    state_t                    state_q, state_d;
    logic [TMR_BITS-1:0]       tmr_q, tmr_d;
    logic [cfg_bits-1:0]       cfg_q, pending_q, ctrl_q;
    logic                      err_q, ack_q, lock_q;
    logic [WB_data_bits-1:0]   dat_q, rd_data;

    logic                      hit, take, wr, ctrl_wr, errclr_wr, busy;
    logic                      in_range, ctrl_accept, ctrl_reject, start_switch;
    logic [1:0]                reg_idx;
    logic [7:0]                req;
    logic [cfg_bits-1:0]       new_sel;

    // A hit arriving while ack is high is only taken on the following cycle,
    // so acks can never appear back to back.
    assign hit       = wbs_stb_i & wbs_cyc_i
                     & (wbs_adr_i[WB_addr_bits-1:4] == CFG_BASE[WB_addr_bits-1:4]);
    assign take      = hit & ~ack_q;
    assign wr        = take & wbs_we_i;
    assign reg_idx   = wbs_adr_i[3:2];
    assign ctrl_wr   = wr & (reg_idx == 2'd0) & wbs_sel_i[0];
    assign errclr_wr = wr & (reg_idx == 2'd2);

    assign req          = wbs_dat_i[7:0];
    assign new_sel      = req[cfg_bits-1:0];
    assign busy         = (state_q != S_IDLE);
    assign in_range     = (req < NUM_MACROS);
    assign ctrl_reject  = ctrl_wr & (busy | lock_q | ~in_range);
    assign ctrl_accept  = ctrl_wr & ~busy & ~lock_q & in_range;
    assign start_switch = ctrl_accept & (new_sel != cfg_q);

    always_comb begin
        rd_data = '0;
        case (reg_idx)
            2'd0: rd_data[cfg_bits-1:0] = ctrl_q;
            2'd1: begin
                rd_data[cfg_bits-1:0] = cfg_q;
                rd_data[8]            = busy;
                rd_data[9]            = err_q;
                rd_data[10]           = lock_q;
            end
            default: rd_data = '0;
        endcase
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        tmr_d        = tmr_q;
        busy_o       = 1'b1;
        io_isolate_o = 1'b1;
        macro_rst_o  = '1;
        case (state_q)
            S_IDLE: begin
                busy_o       = 1'b0;
                io_isolate_o = 1'b0;
                macro_rst_o  = ~(user_macros'(1) << cfg_q);
                if (start_switch) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                io_isolate_o = 1'b0;
                macro_rst_o  = ~(user_macros'(1) << cfg_q);
                if (!wbs_cyc_i) begin
                    state_d = S_ISOLATE;
                    tmr_d   = GUARD_LOAD;
                end
            end
            S_ISOLATE: begin
                if (tmr_q == '0) state_d = S_SWITCH;
                else             tmr_d   = tmr_q - 1'b1;
            end
            S_SWITCH: begin
                state_d = S_RELEASE;
                tmr_d   = RELEASE_LOAD;
            end
            S_RELEASE: begin
                if (tmr_q == '0) state_d = S_IDLE;
                else             tmr_d   = tmr_q - 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= S_IDLE;
            tmr_q     <= '0;
            cfg_q     <= '0;
            pending_q <= '0;
            ctrl_q    <= '0;
            err_q     <= 1'b0;
            ack_q     <= 1'b0;
            dat_q     <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            ack_q   <= take;
            dat_q   <= (take & ~wbs_we_i) ? rd_data : '0;
            if (ctrl_accept)          ctrl_q    <= new_sel;
            if (start_switch)         pending_q <= new_sel;
            if (state_q == S_SWITCH)  cfg_q     <= pending_q;
            if (ctrl_reject)          err_q     <= 1'b1;
            else if (errclr_wr)       err_q     <= 1'b0;
        end
    end

`ifdef MPC_CFG_LOCK_EN
    // Lock is only ever set by an accepted CTRL write; only bus reset clears it.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)                           lock_q <= 1'b0;
        else if (ctrl_accept && wbs_dat_i[31])  lock_q <= 1'b1;
    end
`else
    assign lock_q = 1'b0;
`endif

    assign wbs_ack_o     = ack_q;
    assign wbs_dat_o     = dat_q;
    assign configuration = cfg_q;

    logic unused_ok;
    assign unused_ok = &{1'b0, wbs_sel_i, wbs_dat_i, wbs_adr_i};

endmodule

// File: tb/tb_mpc_cfg_ctrl.sv
// Self-checking bench for mpc_cfg_ctrl: timeline model of the switch sequence
// compared every cycle, plus directed scenarios with literal expectations.
module tb_mpc_cfg_ctrl;

    localparam int          G    = 16;
    localparam int          R    = 8;
    localparam logic [31:0] BASE = 32'h3000_F000;
`ifdef MPC_CFG_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] dat = '0, adr = '0;
    logic        wbs_ack_o, io_isolate_o, busy_o;
    logic [31:0] wbs_dat_o;
    logic [1:0]  configuration;
    logic [3:0]  macro_rst_o;

    int n_checks = 0;
    int n_err    = 0;

    mpc_cfg_ctrl dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (wb_rst_i),
        .wbs_stb_i     (stb),
        .wbs_cyc_i     (cyc),
        .wbs_we_i      (we),
        .wbs_sel_i     (sel),
        .wbs_dat_i     (dat),
        .wbs_adr_i     (adr),
        .wbs_ack_o     (wbs_ack_o),
        .wbs_dat_o     (wbs_dat_o),
        .configuration (configuration),
        .macro_rst_o   (macro_rst_o),
        .io_isolate_o  (io_isolate_o),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A switch is described by the cycle t0 in which the bus was first seen
    // idle after the request; everything else is an offset from t0.
    int          cyc_n = 0;
    bit          m_valid = 1'b0;
    int          m_cfg, m_pend, m_ctrl, t0;
    bit          m_err, m_lock, m_ack, sw_active;
    logic [31:0] m_dat;

    function automatic int exp_cfg(int n);
        if (sw_active && t0 >= 0 && (n - t0) >= G + 2) return m_pend;
        return m_cfg;
    endfunction

    function automatic bit exp_iso(int n);
        return sw_active && t0 >= 0 && (n - t0) >= 1;
    endfunction

    function automatic logic [3:0] exp_rst(int n);
        if (exp_iso(n)) return 4'hF;
        return ~(4'b0001 << exp_cfg(n));
    endfunction

    always @(posedge clk) begin
        if (wb_rst_i) begin
            m_cfg = 0; m_pend = 0; m_ctrl = 0; t0 = -1;
            m_err = 0; m_lock = 0; m_ack = 0; sw_active = 0; m_dat = '0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            bit          busy_now;
            bit          take;
            int          shown;
            logic [31:0] rd;
            busy_now = sw_active;
            shown    = exp_cfg(cyc_n);
            take     = stb && cyc && (adr[31:4] == BASE[31:4]) && !m_ack;
            case (adr[3:2])
                2'd0:    rd = 32'(m_ctrl);
                2'd1:    rd = 32'(shown) | (32'(busy_now) << 8) | (32'(m_err) << 9) | (32'(m_lock) << 10);
                default: rd = 32'h0;
            endcase
            if (sw_active) begin
                if (t0 < 0) begin
                    if (!cyc) t0 = cyc_n;
                end else if (cyc_n + 1 - t0 == G + R + 2) begin
                    sw_active = 0;
                    m_cfg     = m_pend;
                end
            end
            if (take && we) begin
                if (adr[3:2] == 2'd0 && sel[0]) begin
                    if (busy_now || m_lock || dat[7:0] >= 8'd4) m_err = 1;
                    else begin
                        m_ctrl = int'(dat[7:0]);
                        if (LOCK_EN && dat[31]) m_lock = 1;
                        if (int'(dat[7:0]) != m_cfg) begin
                            sw_active = 1;
                            t0        = -1;
                            m_pend    = int'(dat[7:0]);
                        end
                    end
                end else if (adr[3:2] == 2'd2) begin
                    m_err = 0;
                end
            end
            m_ack = take;
            m_dat = (take && !we) ? rd : 32'h0;
        end
        cyc_n++;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("m_ack",  32'(wbs_ack_o),     32'(m_ack));
            check("m_dat",  wbs_dat_o,          m_dat);
            check("m_cfg",  32'(configuration), 32'(exp_cfg(cyc_n)));
            check("m_rst",  32'(macro_rst_o),   32'(exp_rst(cyc_n)));
            check("m_iso",  32'(io_isolate_o),  32'(exp_iso(cyc_n)));
            check("m_busy", 32'(busy_o),        32'(sw_active));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wb_xfer(input bit w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input bit keep_cyc, output logic [31:0] rd);
        int n;
        n = 0;
        rd = '0;
        @(posedge clk); #1;
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat = d; sel = s;
        do begin
            @(negedge clk);
            n++;
        end while (!wbs_ack_o && n < 20);
        check("wb_ack", 32'(wbs_ack_o), 32'd1);
        rd = wbs_dat_o;
        @(posedge clk); #1;
        stb = 1'b0; we = 1'b0;
        if (!keep_cyc) cyc = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy_o && n < 100);
        check("idle_timeout", 32'(busy_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int iso_cnt, busy_zero_at;

        // 1: reset state
        repeat (3) @(posedge clk);
        #1 wb_rst_i = 1'b0;
        @(negedge clk);
        check("rst_cfg",  32'(configuration), 32'd0);
        check("rst_mrst", 32'(macro_rst_o),   32'b1110);
        check("rst_iso",  32'(io_isolate_o),  32'd0);
        check("rst_busy", 32'(busy_o),        32'd0);
        wb_xfer(0, BASE + 4,  0, 4'hF, 0, rd); check("rst_status", rd, 32'h0);
        wb_xfer(0, BASE + 12, 0, 4'hF, 0, rd); check("reg_c_read", rd, 32'h0);

        // no ack outside the window
        @(posedge clk); #1;
        stb = 1'b1; cyc = 1'b1; adr = BASE + 32'h10;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_ack_outside", 32'(wbs_ack_o), 32'd0);
        end
        @(posedge clk); #1;
        stb = 1'b0; cyc = 1'b0;

        // 2: switch to 2, count cycles from first cyc-low drain cycle
        wb_xfer(1, BASE, 32'h2, 4'hF, 0, rd);
        iso_cnt = 0; busy_zero_at = -1;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (io_isolate_o) iso_cnt++;
            if (!busy_o && busy_zero_at < 0) busy_zero_at = n;
        end
        check("sw_iso_cycles", 32'(iso_cnt),      32'd25);
        check("sw_busy_lat",   32'(busy_zero_at), 32'd26);
        check("sw_cfg",        32'(configuration), 32'd2);
        check("sw_mrst",       32'(macro_rst_o),   32'b1011);
        wb_xfer(0, BASE, 0, 4'hF, 0, rd); check("ctrl_readback", rd, 32'h2);

        // 3: out-of-range request, then ERRCLR
        wb_xfer(1, BASE, 32'h5, 4'hF, 0, rd);
        wb_xfer(0, BASE + 4, 0, 4'hF, 0, rd); check("oor_status", rd, 32'h202);
        check("oor_cfg", 32'(configuration), 32'd2);
        wb_xfer(1, BASE + 8, 0, 4'hF, 0, rd);
        wb_xfer(0, BASE + 4, 0, 4'hF, 0, rd); check("errclr_status", rd, 32'h002);

        // equal request and byte-0-disabled write: no switch, no error
        wb_xfer(1, BASE, 32'h2, 4'hF, 0, rd);
        @(negedge clk); check("eq_busy", 32'(busy_o), 32'd0);
        wb_xfer(1, BASE, 32'h1, 4'hE, 0, rd);
        @(negedge clk); check("sel0_busy", 32'(busy_o), 32'd0);
        wb_xfer(0, BASE + 4, 0, 4'hF, 0, rd); check("sel0_status", rd, 32'h002);

        // 4: CTRL=1, then CTRL=3 while isolating
        wb_xfer(1, BASE, 32'h1, 4'hF, 0, rd);
        repeat (5) @(posedge clk);
        wb_xfer(0, BASE + 4, 0, 4'hF, 0, rd); check("mid_status", rd, 32'h102);
        wb_xfer(1, BASE, 32'h3, 4'hF, 0, rd);
        wait_idle();
        check("busy_rej_cfg", 32'(configuration), 32'd1);
        wb_xfer(0, BASE + 4, 0, 4'hF, 0, rd); check("busy_rej_status", rd, 32'h201);
        wb_xfer(1, BASE + 8, 0, 4'hF, 0, rd);

        // 5: cycle held after the ack keeps the sequencer draining
        wb_xfer(1, BASE, 32'h0, 4'hF, 1, rd);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("drain_iso",  32'(io_isolate_o), 32'd0);
            check("drain_busy", 32'(busy_o),       32'd1);
        end
        @(posedge clk); #1 cyc = 1'b0;
        wait_idle();
        check("drain_cfg",  32'(configuration), 32'd0);
        check("drain_mrst", 32'(macro_rst_o),   32'b1110);

        // 6: reset pulse during RELEASE aborts the switch
        wb_xfer(1, BASE, 32'h3, 4'hF, 0, rd);
        repeat (20) @(posedge clk);
        @(negedge clk); check("abort_in_release", 32'(io_isolate_o), 32'd1);
        @(posedge clk); #1 wb_rst_i = 1'b1;
        @(posedge clk); #1 wb_rst_i = 1'b0;
        @(negedge clk);
        check("abort_cfg",  32'(configuration), 32'd0);
        check("abort_mrst", 32'(macro_rst_o),   32'b1110);
        check("abort_busy", 32'(busy_o),        32'd0);
        check("abort_iso",  32'(io_isolate_o),  32'd0);
        wb_xfer(0, BASE, 0, 4'hF, 0, rd); check("abort_ctrl", rd, 32'h0);

        // lock bit: honoured only when the feature is built in
        wb_xfer(1, BASE, 32'h8000_0001, 4'hF, 0, rd);
        wait_idle();
        check("lock_cfg1", 32'(configuration), 32'd1);
        wb_xfer(1, BASE, 32'h2, 4'hF, 0, rd);
        wait_idle();
`ifdef MPC_CFG_LOCK_EN
        check("lock_cfg_held", 32'(configuration), 32'd1);
        wb_xfer(0, BASE + 4, 0, 4'hF, 0, rd); check("lock_status", rd, 32'h601);
`else
        check("nolock_cfg", 32'(configuration), 32'd2);
        wb_xfer(0, BASE + 4, 0, 4'hF, 0, rd); check("nolock_status", rd, 32'h002);
`endif

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
